// File: rtl/uart_cmd_parser.sv
// ============================================================================
// Module   : uart_cmd_parser
// Brief    : Decodes 5-byte UART write frames (SYNC ADDR DH DL CHK) into
//            register write strobes and replies with ACK/NAK.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter logic [7:0] ACK_BYTE    = 8'h06,
  parameter logic [7:0] NAK_BYTE    = 8'h15,
  parameter int         TIMEOUT_CYC = 30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rx_err_i,
  output logic        wr_en_o,
  output logic [7:0]  wr_addr_o,
  output logic [15:0] wr_data_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_busy_i,
  output logic        frame_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GET_ADDR   = 3'd1,
    GET_DH     = 3'd2,
    GET_DL     = 3'd3,
    GET_CHK    = 3'd4,
    SEND_REPLY = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       dh_q, dh_d;
  logic [7:0]       dl_q, dl_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [15:0]      wr_data_q, wr_data_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             frame_err_q, frame_err_d;
  logic             timeout;

  // Byte arrival outranks an expiring counter, so a late byte is still accepted.
  assign timeout = (cnt_q == TIMEOUT_MAX) && !rx_valid_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    addr_d      = addr_q;
    dh_d        = dh_q;
    dl_d        = dl_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    frame_err_d = 1'b0;

    if (rx_valid_i || state_q == IDLE || state_q == SEND_REPLY) begin
      cnt_d = '0;
    end else if (cnt_q != TIMEOUT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rx_valid_i && !rx_err_i && rx_data_i == SYNC_BYTE) begin
          state_d = GET_ADDR;
          sum_d   = '0;
        end
      end
      GET_ADDR, GET_DH, GET_DL, GET_CHK: begin
        if (rx_err_i || (timeout && !rx_valid_i)) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (rx_valid_i) begin
          sum_d = sum_q + rx_data_i;
          case (state_q)
            GET_ADDR: begin addr_d = rx_data_i; state_d = GET_DH; end
            GET_DH:   begin dh_d   = rx_data_i; state_d = GET_DL; end
            GET_DL:   begin dl_d   = rx_data_i; state_d = GET_CHK; end
            default: begin
              state_d = SEND_REPLY;
              if (rx_data_i == sum_q) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = {dh_q, dl_q};
                tx_data_d = ACK_BYTE;
              end else begin
                frame_err_d = 1'b1;
                tx_data_d   = NAK_BYTE;
              end
            end
          endcase
        end
      end
      SEND_REPLY: begin
        if (!tx_busy_i) begin
          tx_start_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sum_q       <= '0;
      addr_q      <= '0;
      dh_q        <= '0;
      dl_q        <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      addr_q      <= addr_d;
      dh_q        <= dh_d;
      dl_q        <= dl_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign tx_data_o   = tx_data_q;
  assign tx_start_o  = tx_start_q;
  assign frame_err_o = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
// ============================================================================
// Module   : tb_uart_cmd_parser
// Brief    : Directed, table-driven self-checking bench for uart_cmd_parser.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_cmd_parser;

  localparam int T = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_err_i;
  logic        tx_busy_i;
  logic        wr_en_o;
  logic [7:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        frame_err_o;

  uart_cmd_parser #(.TIMEOUT_CYC(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_err_i    (rx_err_i),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .tx_data_o   (tx_data_o),
    .tx_start_o  (tx_start_o),
    .tx_busy_i   (tx_busy_i),
    .frame_err_o (frame_err_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Event monitor, sampled on the falling edge.
  int         cyc = 0;
  int         wr_cnt = 0, tx_cnt = 0, fe_cnt = 0, tx_viol = 0;
  int         wr_cyc = 0, fe_cyc = 0, last_rx_cyc = 0;
  logic [7:0] tx_last = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid_i) last_rx_cyc <= cyc;
    if (wr_en_o) begin
      wr_cnt <= wr_cnt + 1;
      wr_cyc <= cyc;
    end
    if (tx_start_o) begin
      tx_cnt  <= tx_cnt + 1;
      tx_last <= tx_data_o;
      if (tx_busy_i) tx_viol <= tx_viol + 1;
    end
    if (frame_err_o) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
    tick(2);
  endtask

  task automatic pulse_err();
    @(posedge clk); #1;
    rx_err_i = 1'b1;
    @(posedge clk); #1;
    rx_err_i = 1'b0;
    tick(2);
  endtask

  task automatic send_frame(input logic [4:0][7:0] fr);
    for (int i = 4; i >= 0; i--) send_byte(fr[i]);
  endtask

  typedef struct {
    string           nm;
    logic [4:0][7:0] fr;
    logic            exp_wr;
    logic [7:0]      exp_addr;
    logic [15:0]     exp_data;
    logic [7:0]      exp_reply;
    logic            exp_fe;
  } vec_t;

  task automatic run_frame(input vec_t v);
    int wr0, tx0, fe0;
    wr0 = wr_cnt; tx0 = tx_cnt; fe0 = fe_cnt;
    send_frame(v.fr);
    tick(8);
    check({v.nm, " wr_en count"}, wr_cnt - wr0, {31'd0, v.exp_wr});
    check({v.nm, " wr_addr"}, {24'd0, wr_addr_o}, {24'd0, v.exp_addr});
    check({v.nm, " wr_data"}, {16'd0, wr_data_o}, {16'd0, v.exp_data});
    if (v.exp_wr) check({v.nm, " wr latency"}, wr_cyc - last_rx_cyc, 32'd1);
    check({v.nm, " tx_start count"}, tx_cnt - tx0, 32'd1);
    check({v.nm, " reply"}, {24'd0, tx_last}, {24'd0, v.exp_reply});
    check({v.nm, " frame_err count"}, fe_cnt - fe0, {31'd0, v.exp_fe});
  endtask

  vec_t vecs [5];

  initial begin
    int wr0, tx0, fe0;

    vecs[0] = '{"good",      40'hA5_10_12_34_56, 1'b1, 8'h10, 16'h1234, 8'h06, 1'b0};
    vecs[1] = '{"badchk",    40'hA5_10_12_34_57, 1'b0, 8'h10, 16'h1234, 8'h15, 1'b1};
    vecs[2] = '{"wrapsum",   40'hA5_FF_FF_FF_FD, 1'b1, 8'hFF, 16'hFFFF, 8'h06, 1'b0};
    vecs[3] = '{"embedsync", 40'hA5_A5_A5_A5_EF, 1'b1, 8'hA5, 16'hA5A5, 8'h06, 1'b0};
    vecs[4] = '{"zeros",     40'hA5_00_00_00_00, 1'b1, 8'h00, 16'h0000, 8'h06, 1'b0};

    rst = 1'b1; rx_data_i = '0; rx_valid_i = 1'b0; rx_err_i = 1'b0; tx_busy_i = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset wr_en",     {31'd0, wr_en_o},     32'd0);
    check("reset wr_addr",   {24'd0, wr_addr_o},   32'd0);
    check("reset wr_data",   {16'd0, wr_data_o},   32'd0);
    check("reset tx_data",   {24'd0, tx_data_o},   32'd0);
    check("reset tx_start",  {31'd0, tx_start_o},  32'd0);
    check("reset frame_err", {31'd0, frame_err_o}, 32'd0);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Garbage before sync, then an embedded A5 taken as ADDR -> NAK.
    wr0 = wr_cnt; tx0 = tx_cnt; fe0 = fe_cnt;
    send_byte(8'h00); send_byte(8'hFF);
    send_frame(40'hA5_A5_01_00_02);
    send_byte(8'h03);
    tick(8);
    check("garbage wr_en count", wr_cnt - wr0, 32'd0);
    check("garbage tx count",    tx_cnt - tx0, 32'd1);
    check("garbage reply",       {24'd0, tx_last}, 32'h15);
    check("garbage frame_err",   fe_cnt - fe0, 32'd1);

    // Inter-byte timeout aborts with frame_err and no reply.
    wr0 = wr_cnt; tx0 = tx_cnt; fe0 = fe_cnt;
    send_byte(8'hA5); send_byte(8'h20);
    tick(T + 10);
    check("timeout frame_err count", fe_cnt - fe0, 32'd1);
    check("timeout frame_err time",  fe_cyc - last_rx_cyc, T + 2);
    check("timeout tx count",        tx_cnt - tx0, 32'd0);
    check("timeout wr count",        wr_cnt - wr0, 32'd0);
    run_frame('{"after_timeout", 40'hA5_20_00_01_21, 1'b1, 8'h20, 16'h0001, 8'h06, 1'b0});

    // rx_err mid-frame aborts.
    wr0 = wr_cnt; tx0 = tx_cnt; fe0 = fe_cnt;
    send_byte(8'hA5); send_byte(8'h30);
    pulse_err();
    tick(4);
    check("rxerr frame_err count", fe_cnt - fe0, 32'd1);
    check("rxerr tx count",        tx_cnt - tx0, 32'd0);
    run_frame('{"after_rxerr", 40'hA5_30_AB_CD_A8, 1'b1, 8'h30, 16'hABCD, 8'h06, 1'b0});

    // rx_err with rx_valid in the same cycle: error wins, byte dropped.
    fe0 = fe_cnt; tx0 = tx_cnt;
    send_byte(8'hA5);
    @(posedge clk); #1;
    rx_data_i = 8'h40; rx_valid_i = 1'b1; rx_err_i = 1'b1;
    @(posedge clk); #1;
    rx_valid_i = 1'b0; rx_err_i = 1'b0;
    tick(4);
    check("simul err frame_err", fe_cnt - fe0, 32'd1);
    run_frame('{"after_simul", 40'hA5_41_00_00_41, 1'b1, 8'h41, 16'h0000, 8'h06, 1'b0});

    // rx_err in IDLE is ignored.
    fe0 = fe_cnt;
    pulse_err();
    check("idle rxerr ignored", fe_cnt - fe0, 32'd0);

    // tx_busy backpressure.
    wr0 = wr_cnt; tx0 = tx_cnt;
    tx_busy_i = 1'b1;
    send_frame(40'hA5_01_02_03_06);
    tick(2);
    check("bp wr immediate",  wr_cnt - wr0, 32'd1);
    check("bp wr latency",    wr_cyc - last_rx_cyc, 32'd1);
    tick(500);
    check("bp tx held off",   tx_cnt - tx0, 32'd0);
    tx_busy_i = 1'b0;
    tick(10);
    check("bp tx single",     tx_cnt - tx0, 32'd1);
    check("bp reply",         {24'd0, tx_last}, 32'h06);

    // Reset during reply wait discards the reply.
    tx0 = tx_cnt;
    tx_busy_i = 1'b1;
    send_frame(40'hA5_02_03_04_09);
    tick(50);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    tx_busy_i = 1'b0;
    tick(20);
    check("rst no tx_start", tx_cnt - tx0, 32'd0);
    check("rst wr_addr",     {24'd0, wr_addr_o}, 32'd0);
    check("rst wr_data",     {16'd0, wr_data_o}, 32'd0);
    check("rst tx_data",     {24'd0, tx_data_o}, 32'd0);
    check("rst frame_err",   {31'd0, frame_err_o}, 32'd0);
    check("tx_start vs busy", tx_viol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
